// File: rtl/wash_program_scheduler.sv
// wash_program_scheduler: latches a wash program and times its wash/spin phases on a prescaled tick
module wash_program_scheduler #(
    parameter int CLK_DIV     = 1000,
    parameter int TW          = 8,
    parameter int WASH_NORMAL = 40,
    parameter int SPIN_NORMAL = 10,
    parameter int WASH_QUICK  = 15,
    parameter int SPIN_QUICK  = 5,
    parameter int WASH_HEAVY  = 60,
    parameter int SPIN_HEAVY  = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    prog_sel,
    input  logic          abort,
    input  logic          pause,
    input  logic          cycle_active,
    input  logic          spin_active,
    output logic          cycle_timeout,
    output logic          spin_timeout,
    output logic          busy,
    output logic          prog_done,
    output logic          fault,
    output logic [2:0]    phase,
    output logic [TW-1:0] remaining
);
    localparam int PW = $clog2(CLK_DIV);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WASH_WAIT = 3'd1,
        WASH_RUN  = 3'd2,
        SPIN_WAIT = 3'd3,
        SPIN_RUN  = 3'd4,
        DONE      = 3'd5
    } state_t;
    state_t        state;
    logic [PW-1:0] presc;
    logic [1:0]    prog_q;
    logic [TW-1:0] wash_dur, spin_dur;
    logic          tick, run_act;
    // a zero-length phase still lasts one tick so every phase ends with a pulse
    function automatic logic [TW-1:0] clamp(input int d);
        return d == 0 ? TW'(1) : TW'(d);
    endfunction
    always_comb begin
        wash_dur = prog_q == 2'd1 ? clamp(WASH_QUICK) : prog_q == 2'd2 ? clamp(WASH_HEAVY) : clamp(WASH_NORMAL);
        spin_dur = prog_q == 2'd1 ? clamp(SPIN_QUICK) : prog_q == 2'd2 ? clamp(SPIN_HEAVY) : clamp(SPIN_NORMAL);
    end
    assign tick    = presc == PW'(CLK_DIV - 1);
    assign run_act = state == SPIN_RUN ? spin_active : cycle_active;
    assign phase   = state;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            presc         <= '0;
            prog_q        <= '0;
            remaining     <= '0;
            busy          <= 1'b0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            prog_done     <= 1'b0;
            fault         <= 1'b0;
        end else begin
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            prog_done     <= 1'b0;
            fault         <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                presc     <= '0;
                remaining <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && prog_sel == 2'd3) begin
                            fault <= 1'b1;
                        end else if (start) begin
                            prog_q <= prog_sel;
                            state  <= WASH_WAIT;
                            busy   <= 1'b1;
                        end
                    end
                    WASH_WAIT: begin
                        if (cycle_active) begin
                            remaining <= wash_dur;
                            presc     <= '0;
                            state     <= WASH_RUN;
                        end
                    end
                    SPIN_WAIT: begin
                        if (spin_active) begin
                            remaining <= spin_dur;
                            presc     <= '0;
                            state     <= SPIN_RUN;
                        end
                    end
                    WASH_RUN, SPIN_RUN: begin
                        if (!run_act) begin
                            fault     <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                            presc     <= '0;
                            remaining <= '0;
                        end else if (!pause) begin
                            presc <= tick ? '0 : presc + 1'b1;
                            if (tick)
                                remaining <= remaining - 1'b1;
                            if (tick && remaining == TW'(1)) begin
                                if (state == WASH_RUN) begin
                                    cycle_timeout <= 1'b1;
                                    state         <= SPIN_WAIT;
                                end else begin
                                    spin_timeout <= 1'b1;
                                    state        <= DONE;
                                end
                            end
                        end
                    end
                    DONE: begin
                        prog_done <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wash_program_scheduler.sv
// tb_wash_program_scheduler: scenario tasks and randomized programs checked against a tick-arithmetic model
module tb_wash_program_scheduler;
    localparam int CDIV = 4;
    localparam int WN = 40, SN = 10, WQ = 3, SQ = 2, WH = 60, SH = 0;
    logic       clk = 0, reset = 1, start = 0, abort = 0, pause = 0;
    logic       cycle_active = 0, spin_active = 0;
    logic [1:0] prog_sel = 0;
    logic       cycle_timeout, spin_timeout, busy, prog_done, fault;
    logic [2:0] phase;
    logic [7:0] remaining;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    wash_program_scheduler #(
        .CLK_DIV(CDIV), .TW(8),
        .WASH_NORMAL(WN), .SPIN_NORMAL(SN),
        .WASH_QUICK(WQ), .SPIN_QUICK(SQ),
        .WASH_HEAVY(WH), .SPIN_HEAVY(SH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
        .abort(abort), .pause(pause), .cycle_active(cycle_active),
        .spin_active(spin_active), .cycle_timeout(cycle_timeout),
        .spin_timeout(spin_timeout), .busy(busy), .prog_done(prog_done),
        .fault(fault), .phase(phase), .remaining(remaining)
    );

    function automatic int wash_d(input int p);
        int d;
        d = p == 1 ? WQ : p == 2 ? WH : WN;
        return d == 0 ? 1 : d;
    endfunction

    function automatic int spin_d(input int p);
        int d;
        d = p == 1 ? SQ : p == 2 ? SH : SN;
        return d == 0 ? 1 : d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // pulses must be mutually exclusive and busy must mirror "not IDLE" on every cycle
    always @(negedge clk) begin
        if (!reset) begin
            vectors++;
            if ($countones({cycle_timeout, spin_timeout, prog_done, fault}) > 1 || busy !== (phase != 3'd0)) begin
                miscompares++;
                $display("FAIL monitor pulses=%b busy=%b phase=%0d want <=1 pulse and busy=(phase!=0)",
                         {cycle_timeout, spin_timeout, prog_done, fault}, busy, phase);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation exceeded time bound");
        $fatal(1);
    end

    task automatic start_prog(input int p);
        prog_sel = 2'(p);
        start = 1;
        step();
        start = 0;
        vectors++;
        if (phase !== 3'd1 || busy !== 1'b1 || fault !== 1'b0 || remaining !== 8'd0) begin
            miscompares++;
            $display("FAIL start_prog%0d phase=%0d busy=%b fault=%b rem=%0d want phase=1 busy=1 fault=0 rem=0",
                     p, phase, busy, fault, remaining);
        end
    endtask

    task automatic run_phase(input string tag, input bit spin, input int d, input int pause_at,
                             input int pause_len, input bit rnd_sel);
        int total, unp;
        logic to;
        total = d * CDIV + pause_len;
        unp = 0;
        pause = 1'($urandom);
        if (spin) spin_active = 1; else cycle_active = 1;
        step();
        vectors++;
        if (phase !== (spin ? 3'd4 : 3'd2) || remaining !== 8'(d)) begin
            miscompares++;
            $display("FAIL %s_load phase=%0d rem=%0d want phase=%0d rem=%0d",
                     tag, phase, remaining, spin ? 4 : 2, d);
        end
        for (int n = 1; n <= total; n++) begin
            pause = (n > pause_at && n <= pause_at + pause_len);
            if (rnd_sel) prog_sel = 2'($urandom);
            unp += pause ? 0 : 1;
            step();
            to = spin ? spin_timeout : cycle_timeout;
            vectors++;
            if (to !== (n == total) || remaining !== 8'(d - unp / CDIV)) begin
                miscompares++;
                $display("FAIL %s_cyc%0d timeout=%b rem=%0d want timeout=%b rem=%0d",
                         tag, n, to, remaining, n == total, d - unp / CDIV);
            end
            if (n == total) begin
                vectors++;
                if (phase !== (spin ? 3'd5 : 3'd3)) begin
                    miscompares++;
                    $display("FAIL %s_end phase=%0d want %0d", tag, phase, spin ? 5 : 3);
                end
            end
        end
        pause = 0;
        if (spin) spin_active = 0; else cycle_active = 0;
    endtask

    task automatic run_program(input int p, input int wpa, input int wpl, input int spa, input int spl,
                               input bit rnd);
        int waits;
        start_prog(p);
        waits = rnd ? $urandom_range(0, 3) : 1;
        for (int i = 0; i < waits; i++) begin
            pause = 1'($urandom);
            step();
            vectors++;
            if (phase !== 3'd1 || remaining !== 8'd0) begin
                miscompares++;
                $display("FAIL wash_wait phase=%0d rem=%0d want phase=1 rem=0", phase, remaining);
            end
        end
        run_phase("wash", 1'b0, wash_d(p), wpa, wpl, rnd);
        for (int i = 0; i < waits; i++) begin
            pause = 1'($urandom);
            step();
            vectors++;
            if (phase !== 3'd3 || cycle_timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL spin_wait phase=%0d cto=%b want phase=3 cto=0", phase, cycle_timeout);
            end
        end
        run_phase("spin", 1'b1, spin_d(p), spa, spl, rnd);
        step();
        vectors++;
        if (prog_done !== 1'b1 || busy !== 1'b0 || phase !== 3'd0 || spin_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL done prog_done=%b busy=%b phase=%0d sto=%b want 1 0 0 0",
                     prog_done, busy, phase, spin_timeout);
        end
        step();
        vectors++;
        if (prog_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_after prog_done=%b busy=%b want 0 0", prog_done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        step();
        vectors++;
        if ({cycle_timeout, spin_timeout, busy, prog_done, fault} !== 5'b0 || phase !== 3'd0 || remaining !== 8'd0) begin
            miscompares++;
            $display("FAIL reset outs=%b phase=%0d rem=%0d want all zero",
                     {cycle_timeout, spin_timeout, busy, prog_done, fault}, phase, remaining);
        end
        reset = 0;
        step();
    endtask

    task automatic test_quick();
        run_program(1, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_illegal();
        prog_sel = 2'd3;
        start = 1;
        step();
        start = 0;
        vectors++;
        if (fault !== 1'b1 || busy !== 1'b0 || phase !== 3'd0 || cycle_timeout !== 1'b0 || spin_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal fault=%b busy=%b phase=%0d want fault=1 busy=0 phase=0", fault, busy, phase);
        end
        step();
        vectors++;
        if (fault !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_after fault=%b busy=%b want 0 0", fault, busy);
        end
    endtask

    task automatic test_pause();
        run_program(1, 5, 5, 2, 3, 1'b0);
    endtask

    task automatic test_drop();
        start_prog(1);
        cycle_active = 1;
        step();
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (remaining !== 8'd2) begin
            miscompares++;
            $display("FAIL drop_pre rem=%0d want 2", remaining);
        end
        cycle_active = 0;
        step();
        vectors++;
        if (fault !== 1'b1 || phase !== 3'd0 || busy !== 1'b0 || cycle_timeout !== 1'b0 || remaining !== 8'd0) begin
            miscompares++;
            $display("FAIL drop fault=%b phase=%0d busy=%b cto=%b rem=%0d want 1 0 0 0 0",
                     fault, phase, busy, cycle_timeout, remaining);
        end
        step();
        vectors++;
        if (fault !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_after fault=%b want 0", fault);
        end
    endtask

    task automatic test_abort();
        start_prog(1);
        run_phase("abort_wash", 1'b0, wash_d(1), 0, 0, 1'b0);
        spin_active = 1;
        step();
        for (int i = 0; i < 3; i++) step();
        abort = 1;
        start = 1;
        prog_sel = 2'd0;
        step();
        vectors++;
        if (phase !== 3'd0 || remaining !== 8'd0 || busy !== 1'b0 ||
            {cycle_timeout, spin_timeout, prog_done, fault} !== 4'b0) begin
            miscompares++;
            $display("FAIL abort phase=%0d rem=%0d busy=%b pulses=%b want 0 0 0 0000",
                     phase, remaining, busy, {cycle_timeout, spin_timeout, prog_done, fault});
        end
        step();
        vectors++;
        if (phase !== 3'd0 || busy !== 1'b0 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_start phase=%0d busy=%b fault=%b want 0 0 0", phase, busy, fault);
        end
        abort = 0;
        start = 0;
        spin_active = 0;
        step();
        run_program(0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        start_prog(0);
        cycle_active = 1;
        step();
        for (int i = 0; i < 10; i++) step();
        #2 reset = 1;
        #1;
        vectors++;
        if ({cycle_timeout, spin_timeout, busy, prog_done, fault} !== 5'b0 || phase !== 3'd0 || remaining !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid outs=%b phase=%0d rem=%0d want all zero",
                     {cycle_timeout, spin_timeout, busy, prog_done, fault}, phase, remaining);
        end
        cycle_active = 0;
        step();
        reset = 0;
        step();
    endtask

    task automatic test_zero_duration();
        run_program(2, 7, 2, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        int p, wd, sd;
        for (int k = 0; k < 6; k++) begin
            p = $urandom_range(0, 2);
            wd = wash_d(p) * CDIV;
            sd = spin_d(p) * CDIV;
            run_program(p, $urandom_range(0, wd - 1), $urandom_range(0, 6),
                        $urandom_range(0, sd - 1), $urandom_range(0, 6), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_quick();
        test_illegal();
        test_pause();
        test_drop();
        test_abort();
        test_reset_mid();
        test_zero_duration();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
